valid_lane_packer: RTL and testbench
====================================

# valid_lane_packer

Consumer of the 8-lane valid-sort stage. Each input beat carries eight 32-bit words plus per-lane valid bits, with the valid words already sorted into the top lanes. The packer removes the invalid lanes and concatenates the valid words across beats into dense 8-word lines. On end of input it flushes the partial line, with explicit per-lane valid bits and a word count, toward the memory write path.

## Interface
Parameters: none. Lane count (8) and word width (32) are fixed, matching the sort stage.

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; one clock; synchronous, active-high
- word_in_valid  in  1  input beat present this cycle
- word_in0..word_in7  in  32 each  lane data
- valid_in0..valid_in7  in  1 each  lane valid; legal patterns are n ones in lanes 8-n..7 (n = 0..8)
- last_input_in  in  1  final beat of the stream; sampled only when word_in_valid=1
- control_in  in  2  sideband tag; sampled only when word_in_valid=1
- line_out0..line_out7  out  32 each  packed line, filled from lane 0 upward
- line_valid_out0..line_valid_out7  out  1 each  lane k high iff k < count_out
- count_out  out  4  words in the emitted line (0..8)
- line_out_valid  out  1  one-cycle pulse; line_* and the sideband outputs are meaningful
- last_out  out  1  emitted line is the final line of the stream
- control_out  out  2  control_in of the beat that produced the line
- err_out  out  1  sticky protocol error

## Operation
- State machine: ACTIVE (normal) and FLUSH (emit leftover after an overflowing last beat). Reset enters ACTIVE.
- Internal storage:
  - buffer of 7 x 32-bit words
  - fill counter f, 3-bit, range 0..7
- Per accepted beat (word_in_valid=1, state ACTIVE):
  - n = popcount(valid_in0..7).
  - Incoming valid words are taken in ascending lane order: 8-n, …, 7.
  - The sequence is buffer[0..f-1] followed by the incoming words; t = f+n.
- t >= 8:
  - Emit a line of the first 8 words: count_out=8, line_out_valid=1.
  - Store the remaining t-8 words at buffer[0..]; f <= t-8.
- t < 8 and last_input_in=0:
  - Append the incoming words to the buffer; f <= t; no output.
- last_input_in=1, one of three cases:
  - t < 8: emit the partial line (count_out=t, lanes >= t data 0, valid 0) with last_out=1; f <= 0.
  - t == 8: emit the full line with last_out=1; f <= 0.
  - t > 8:
    - Emit the full line with last_out=0, buffer the t-8 leftover words, enter FLUSH.
    - Next cycle, emit the partial line (count t-8) with last_out=1 and control_out unchanged; f <= 0; return to ACTIVE.
- Empty terminator: last beat with t=0 emits a line with count_out=0, all line_valid_out=0, last_out=1.
- Errors set err_out=1. err_out is cleared only by rst.
  - Illegal valid pattern: the beat is still processed using n = popcount and lanes 8-n..7.
  - word_in_valid=1 while in FLUSH: the beat is dropped.
- word_in_valid=0: no state change.

## Timing
- Latency: one cycle. Outputs are registered on the edge after the beat is sampled; FLUSH output follows one cycle after that.
- Throughput: one beat per cycle. There is no backpressure; upstream must leave the cycle after an overflowing last beat empty.
- line_out_valid is deasserted in every cycle with no emission. line data then holds its previous value; last_out is 0.
- Reset values:
  - all line_out=0, all line_valid_out=0
  - count_out=0, line_out_valid=0, last_out=0, control_out=0, err_out=0
  - f=0, state ACTIVE
- Reset mid-stream discards buffered words with no flush line.
- A new stream may start on the beat directly after a non-overflowing last beat, or directly after the FLUSH cycle.

## Test plan
- Full beats: two beats, all 8 valid, data 0x10..0x17 then 0x20..0x27 → two lines, one cycle after each beat, identical lane order, count 8, last_out=0.
- Accumulate:
  - Beats with n=3 (lanes 5..7 = A,B,C), n=3 (D,E,F), n=3 (G,H,I).
  - Expected: no output after beats 1–2; after beat 3, line A..H, count 8; f=1 holding I.
- Overflow on last:
  - f=5 (words W0..W4), then a last beat with n=6 (X0..X5), control_in=2.
  - Expected cycle +1: line W0..W4,X0..X2, last_out=0, control_out=2.
  - Expected cycle +2: count 3 (X3..X5), lanes 3..7 zero/invalid, last_out=1, control_out=2.
- Empty terminator: f=0, last beat with n=0 → one line, count_out=0, all valid low, last_out=1.
- Errors:
  - valid pattern 0b0000_0101 (lanes 0 and 2 set) → err_out=1 from next cycle onward.
  - Beat presented during FLUSH → dropped; err_out stays 1 until rst.
- Reset mid-stream: f=6, assert rst one cycle → no line emitted, all outputs 0; a subsequent full beat emits exactly its own 8 words.

Source files
------------

// File: rtl/valid_lane_packer.sv
// Packs sorted 8-lane input beats into dense 8-word lines, dropping invalid lanes.
// A last beat that overflows a line spills its leftover words through a one-cycle FLUSH state.
module valid_lane_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        word_in_valid,
  input  logic [31:0] word_in0,
  input  logic [31:0] word_in1,
  input  logic [31:0] word_in2,
  input  logic [31:0] word_in3,
  input  logic [31:0] word_in4,
  input  logic [31:0] word_in5,
  input  logic [31:0] word_in6,
  input  logic [31:0] word_in7,
  input  logic        valid_in0,
  input  logic        valid_in1,
  input  logic        valid_in2,
  input  logic        valid_in3,
  input  logic        valid_in4,
  input  logic        valid_in5,
  input  logic        valid_in6,
  input  logic        valid_in7,
  input  logic        last_input_in,
  input  logic [1:0]  control_in,
  output logic [31:0] line_out0,
  output logic [31:0] line_out1,
  output logic [31:0] line_out2,
  output logic [31:0] line_out3,
  output logic [31:0] line_out4,
  output logic [31:0] line_out5,
  output logic [31:0] line_out6,
  output logic [31:0] line_out7,
  output logic        line_valid_out0,
  output logic        line_valid_out1,
  output logic        line_valid_out2,
  output logic        line_valid_out3,
  output logic        line_valid_out4,
  output logic        line_valid_out5,
  output logic        line_valid_out6,
  output logic        line_valid_out7,
  output logic [3:0]  count_out,
  output logic        line_out_valid,
  output logic        last_out,
  output logic [1:0]  control_out,
  output logic        err_out
);

  typedef enum logic {
    ST_ACTIVE,
    ST_FLUSH
  } state_e;

  logic [31:0] word_arr [8];
  logic [7:0]  valid_vec;

  assign word_arr[0] = word_in0;
  assign word_arr[1] = word_in1;
  assign word_arr[2] = word_in2;
  assign word_arr[3] = word_in3;
  assign word_arr[4] = word_in4;
  assign word_arr[5] = word_in5;
  assign word_arr[6] = word_in6;
  assign word_arr[7] = word_in7;
  assign valid_vec   = {valid_in7, valid_in6, valid_in5, valid_in4,
                        valid_in3, valid_in2, valid_in1, valid_in0};

  state_e      state_q, state_d;
  logic [2:0]  fill_q, fill_d;
  logic [31:0] hold_q [7];
  logic [31:0] hold_d [7];
  logic [31:0] line_q [8];
  logic [31:0] line_d [8];
  logic [7:0]  line_valid_q, line_valid_d;
  logic [3:0]  count_q, count_d;
  logic        line_out_valid_q, line_out_valid_d;
  logic        last_q, last_d;
  logic [1:0]  control_q, control_d;
  logic        err_q, err_d;

  logic [3:0]  pop_n;
  logic [3:0]  total;
  logic        pattern_ok;
  logic [31:0] seq [15];
  logic [31:0] emit_src [8];
  logic        emit;
  logic [3:0]  emit_count;

  // NOTE: combinational blocks use blocking '=' so later statements see earlier results;
  // every variable gets a default at the top so no latch is inferred.
  always_comb begin
    pop_n = '0;
    for (int k = 0; k < 8; k++) begin
      pop_n = pop_n + 4'(valid_vec[k]);
    end
  end

  // A legal pattern is exactly the top pop_n lanes set.
  assign pattern_ok = (valid_vec == 8'(16'hFF00 >> pop_n));
  assign total      = {1'b0, fill_q} + pop_n;

  // Buffered words first, then incoming valid words in ascending lane order, zero beyond.
  always_comb begin
    for (int i = 0; i < 15; i++) begin
      seq[i] = '0;
    end
    for (int j = 0; j < 8; j++) begin
      if (j < int'(pop_n)) begin
        seq[4'(int'(fill_q) + j)] = word_arr[3'(8 - int'(pop_n) + j)];
      end
    end
    for (int i = 0; i < 7; i++) begin
      if (i < int'(fill_q)) begin
        seq[i] = hold_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ACTIVE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ACTIVE: begin
        if (word_in_valid && last_input_in && (total > 4'd8)) begin
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: state_d = ST_ACTIVE;
    endcase
  end

  always_comb begin
    hold_d           = hold_q;
    fill_d           = fill_q;
    line_d           = line_q;
    line_valid_d     = line_valid_q;
    count_d          = count_q;
    line_out_valid_d = 1'b0;
    last_d           = 1'b0;
    control_d        = control_q;
    err_d            = err_q;
    emit             = 1'b0;
    emit_count       = '0;
    for (int k = 0; k < 8; k++) begin
      emit_src[k] = seq[k];
    end

    case (state_q)
      ST_ACTIVE: begin
        if (word_in_valid) begin
          if (!pattern_ok) begin
            err_d = 1'b1;
          end
          for (int i = 0; i < 7; i++) begin
            hold_d[i] = (total >= 4'd8) ? seq[i + 8] : seq[i];
          end
          if (total >= 4'd8) begin
            emit       = 1'b1;
            emit_count = 4'd8;
            last_d     = last_input_in && (total == 4'd8);
            fill_d     = 3'(total - 4'd8);
          end else if (last_input_in) begin
            emit       = 1'b1;
            emit_count = total;
            last_d     = 1'b1;
            fill_d     = '0;
          end else begin
            fill_d = total[2:0];
          end
          if (emit) begin
            control_d = control_in;
          end
        end
      end
      ST_FLUSH: begin
        // Leftover of the overflowing last beat; control_out keeps that beat's tag.
        for (int k = 0; k < 7; k++) begin
          emit_src[k] = hold_q[k];
        end
        emit_src[7] = '0;
        emit        = 1'b1;
        emit_count  = {1'b0, fill_q};
        last_d      = 1'b1;
        fill_d      = '0;
        if (word_in_valid) begin
          err_d = 1'b1;
        end
      end
    endcase

    if (emit) begin
      line_out_valid_d = 1'b1;
      count_d          = emit_count;
      for (int k = 0; k < 8; k++) begin
        line_valid_d[k] = (k < int'(emit_count));
        line_d[k]       = (k < int'(emit_count)) ? emit_src[k] : '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fill_q           <= '0;
      line_q           <= '{default: '0};
      line_valid_q     <= '0;
      count_q          <= '0;
      line_out_valid_q <= 1'b0;
      last_q           <= 1'b0;
      control_q        <= '0;
      err_q            <= 1'b0;
    end else begin
      fill_q           <= fill_d;
      line_q           <= line_d;
      line_valid_q     <= line_valid_d;
      count_q          <= count_d;
      line_out_valid_q <= line_out_valid_d;
      last_q           <= last_d;
      control_q        <= control_d;
      err_q            <= err_d;
    end
  end

  // NOTE: the word buffer has no reset; fill_q alone says which entries are live,
  // so clearing the storage would add reset fan-out for no behavioural gain.
  always_ff @(posedge clk) begin
    hold_q <= hold_d;
  end

  assign line_out0       = line_q[0];
  assign line_out1       = line_q[1];
  assign line_out2       = line_q[2];
  assign line_out3       = line_q[3];
  assign line_out4       = line_q[4];
  assign line_out5       = line_q[5];
  assign line_out6       = line_q[6];
  assign line_out7       = line_q[7];
  assign line_valid_out0 = line_valid_q[0];
  assign line_valid_out1 = line_valid_q[1];
  assign line_valid_out2 = line_valid_q[2];
  assign line_valid_out3 = line_valid_q[3];
  assign line_valid_out4 = line_valid_q[4];
  assign line_valid_out5 = line_valid_q[5];
  assign line_valid_out6 = line_valid_q[6];
  assign line_valid_out7 = line_valid_q[7];
  assign count_out       = count_q;
  assign line_out_valid  = line_out_valid_q;
  assign last_out        = last_q;
  assign control_out     = control_q;
  assign err_out         = err_q;

endmodule

// File: tb/tb_valid_lane_packer.sv
// Scoreboard bench for valid_lane_packer: directed beats push expected lines,
// a negedge monitor pops and compares every emitted line.
module tb_valid_lane_packer;

  typedef logic [7:0][31:0] line_t;

  typedef struct {
    line_t      data;
    logic [3:0] count;
    logic       last;
    logic [1:0] ctrl;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        word_in_valid;
  line_t       word_in;
  logic [7:0]  valid_in;
  logic        last_input_in;
  logic [1:0]  control_in;
  logic [31:0] line_out [8];
  logic [7:0]  line_valid_out;
  logic [3:0]  count_out;
  logic        line_out_valid;
  logic        last_out;
  logic [1:0]  control_out;
  logic        err_out;

  int checks   = 0;
  int failures = 0;
  int line_idx = 0;
  exp_t sb [$];

  always #5 clk = ~clk;

  valid_lane_packer dut (
    .clk             (clk),
    .rst             (rst),
    .word_in_valid   (word_in_valid),
    .word_in0        (word_in[0]),
    .word_in1        (word_in[1]),
    .word_in2        (word_in[2]),
    .word_in3        (word_in[3]),
    .word_in4        (word_in[4]),
    .word_in5        (word_in[5]),
    .word_in6        (word_in[6]),
    .word_in7        (word_in[7]),
    .valid_in0       (valid_in[0]),
    .valid_in1       (valid_in[1]),
    .valid_in2       (valid_in[2]),
    .valid_in3       (valid_in[3]),
    .valid_in4       (valid_in[4]),
    .valid_in5       (valid_in[5]),
    .valid_in6       (valid_in[6]),
    .valid_in7       (valid_in[7]),
    .last_input_in   (last_input_in),
    .control_in      (control_in),
    .line_out0       (line_out[0]),
    .line_out1       (line_out[1]),
    .line_out2       (line_out[2]),
    .line_out3       (line_out[3]),
    .line_out4       (line_out[4]),
    .line_out5       (line_out[5]),
    .line_out6       (line_out[6]),
    .line_out7       (line_out[7]),
    .line_valid_out0 (line_valid_out[0]),
    .line_valid_out1 (line_valid_out[1]),
    .line_valid_out2 (line_valid_out[2]),
    .line_valid_out3 (line_valid_out[3]),
    .line_valid_out4 (line_valid_out[4]),
    .line_valid_out5 (line_valid_out[5]),
    .line_valid_out6 (line_valid_out[6]),
    .line_valid_out7 (line_valid_out[7]),
    .count_out       (count_out),
    .line_out_valid  (line_out_valid),
    .last_out        (last_out),
    .control_out     (control_out),
    .err_out         (err_out)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Lanes 8-n..7 carry base, base+1, ...; lower lanes carry junk the packer must ignore.
  function automatic line_t beat_words(input logic [31:0] base, input int n);
    line_t w;
    for (int k = 0; k < 8; k++) begin
      w[k] = (k >= 8 - n) ? base + 32'(k - (8 - n)) : 32'hDEAD_0000 + 32'(k);
    end
    return w;
  endfunction

  function automatic logic [7:0] top_mask(input int n);
    logic [7:0] m;
    m = '0;
    for (int k = 0; k < 8; k++) begin
      if (k >= 8 - n) m[k] = 1'b1;
    end
    return m;
  endfunction

  // Lanes 0..n-1 = base, base+1, ...; remaining lanes zero.
  function automatic line_t run_line(input logic [31:0] base, input int n);
    line_t d;
    for (int k = 0; k < 8; k++) begin
      d[k] = (k < n) ? base + 32'(k) : 32'h0;
    end
    return d;
  endfunction

  task automatic expect_line(input line_t d, input logic [3:0] count, input logic last,
                             input logic [1:0] ctrl);
    exp_t e;
    e.data  = d;
    e.count = count;
    e.last  = last;
    e.ctrl  = ctrl;
    sb.push_back(e);
  endtask

  task automatic beat(input line_t w, input logic [7:0] v, input logic last, input logic [1:0] ctrl);
    word_in       = w;
    valid_in      = v;
    last_input_in = last;
    control_in    = ctrl;
    word_in_valid = 1'b1;
    @(posedge clk);
    #1;
    word_in_valid = 1'b0;
    last_input_in = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("%s.line_out%0d", tag, k), 64'(line_out[k]), 64'h0);
    end
    check({tag, ".line_valid_out"}, 64'(line_valid_out), 64'h0);
    check({tag, ".count_out"}, 64'(count_out), 64'h0);
    check({tag, ".line_out_valid"}, 64'(line_out_valid), 64'h0);
    check({tag, ".last_out"}, 64'(last_out), 64'h0);
    check({tag, ".control_out"}, 64'(control_out), 64'h0);
    check({tag, ".err_out"}, 64'(err_out), 64'h0);
  endtask

  always @(negedge clk) begin
    if (!rst && line_out_valid) begin
      if (sb.size() == 0) begin
        check($sformatf("unexpected_line%0d", line_idx), 64'(1), 64'(0));
      end else begin
        exp_t e;
        logic [7:0] vmask;
        e = sb.pop_front();
        vmask = '0;
        for (int k = 0; k < 8; k++) begin
          if (k < int'(e.count)) vmask[k] = 1'b1;
          check($sformatf("line%0d.lane%0d", line_idx, k), 64'(line_out[k]), 64'(e.data[k]));
        end
        check($sformatf("line%0d.valid", line_idx), 64'(line_valid_out), 64'(vmask));
        check($sformatf("line%0d.count", line_idx), 64'(count_out), 64'(e.count));
        check($sformatf("line%0d.last", line_idx), 64'(last_out), 64'(e.last));
        check($sformatf("line%0d.control", line_idx), 64'(control_out), 64'(e.ctrl));
      end
      line_idx++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    line_t d;
    line_t w;
    rst           = 1'b1;
    word_in_valid = 1'b0;
    word_in       = '0;
    valid_in      = '0;
    last_input_in = 1'b0;
    control_in    = '0;
    idle(2);
    rst = 1'b0;
    check_reset_outputs("reset");

    // Full beats pass straight through.
    expect_line(run_line(32'h10, 8), 4'd8, 1'b0, 2'd1);
    beat(beat_words(32'h10, 8), 8'hFF, 1'b0, 2'd1);
    expect_line(run_line(32'h20, 8), 4'd8, 1'b0, 2'd3);
    beat(beat_words(32'h20, 8), 8'hFF, 1'b0, 2'd3);

    // Accumulate three n=3 beats; the ninth word stays buffered and ends the stream.
    beat(beat_words(32'h100, 3), top_mask(3), 1'b0, 2'd0);
    beat(beat_words(32'h103, 3), top_mask(3), 1'b0, 2'd0);
    expect_line(run_line(32'h100, 8), 4'd8, 1'b0, 2'd0);
    beat(beat_words(32'h106, 3), top_mask(3), 1'b0, 2'd0);
    expect_line(run_line(32'h108, 1), 4'd1, 1'b1, 2'd2);
    beat(beat_words(32'h0, 0), 8'h00, 1'b1, 2'd2);
    idle(1);

    // Overflow on last: f=5 plus n=6 gives a full line then a 3-word flush line.
    beat(beat_words(32'h200, 5), top_mask(5), 1'b0, 2'd0);
    d = run_line(32'h200, 5);
    d[5] = 32'h300;
    d[6] = 32'h301;
    d[7] = 32'h302;
    expect_line(d, 4'd8, 1'b0, 2'd2);
    expect_line(run_line(32'h303, 3), 4'd3, 1'b1, 2'd2);
    beat(beat_words(32'h300, 6), top_mask(6), 1'b1, 2'd2);
    idle(1);

    // Empty terminator.
    expect_line('0, 4'd0, 1'b1, 2'd1);
    beat(beat_words(32'h0, 0), 8'h00, 1'b1, 2'd1);

    // Last beat landing exactly on a full line.
    beat(beat_words(32'h400, 4), top_mask(4), 1'b0, 2'd0);
    expect_line(run_line(32'h400, 8), 4'd8, 1'b1, 2'd3);
    beat(beat_words(32'h404, 4), top_mask(4), 1'b1, 2'd3);
    idle(1);

    // Illegal valid pattern: still taken as n=2 from lanes 6,7.
    check("err_before_illegal", 64'(err_out), 64'h0);
    for (int k = 0; k < 8; k++) w[k] = 32'h500 + 32'(k);
    beat(w, 8'b0000_0101, 1'b0, 2'd0);
    check("err_after_illegal", 64'(err_out), 64'h1);
    d = '0;
    d[0] = 32'h506;
    d[1] = 32'h507;
    for (int k = 2; k < 8; k++) d[k] = 32'h600 + 32'(k - 2);
    expect_line(d, 4'd8, 1'b1, 2'd0);
    beat(beat_words(32'h600, 6), top_mask(6), 1'b1, 2'd0);
    idle(1);

    // Beat presented during FLUSH is dropped.
    beat(beat_words(32'h700, 7), top_mask(7), 1'b0, 2'd0);
    d = run_line(32'h700, 7);
    d[7] = 32'h710;
    expect_line(d, 4'd8, 1'b0, 2'd1);
    expect_line(run_line(32'h711, 2), 4'd2, 1'b1, 2'd1);
    beat(beat_words(32'h710, 3), top_mask(3), 1'b1, 2'd1);
    beat(beat_words(32'h800, 8), 8'hFF, 1'b0, 2'd3);
    check("err_sticky_after_drop", 64'(err_out), 64'h1);
    expect_line(run_line(32'h900, 8), 4'd8, 1'b0, 2'd2);
    beat(beat_words(32'h900, 8), 8'hFF, 1'b0, 2'd2);
    idle(1);
    check("err_still_set", 64'(err_out), 64'h1);

    // Reset mid-stream discards the six buffered words.
    beat(beat_words(32'hA00, 6), top_mask(6), 1'b0, 2'd0);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check_reset_outputs("midreset");
    expect_line(run_line(32'hB00, 8), 4'd8, 1'b0, 2'd1);
    beat(beat_words(32'hB00, 8), 8'hFF, 1'b0, 2'd1);
    idle(3);

    check("lines_outstanding", 64'(sb.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
